store_buffer: RTL

//   Circular FIFO of pending stores that sits directly downstream of the load/store controller.

---
 rtl/store_buffer_if.sv | 27 ++
 rtl/store_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Drain-side bus between the store buffer and data memory.
// The buffer holds req/addr/data stable until memory acks.
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_data,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_data,
        output mem_ack
    );

endinterface

// File: rtl/store_buffer.sv
// Circular FIFO of pending stores with in-order drain to memory
// and youngest-match store-to-load forwarding.
module store_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DW-1:0]            wr_data,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     lookup_en,
    input  logic [AW-1:0]            lookup_addr,
    output logic [DW-1:0]            read_data,
    output logic                     read_valid,
    store_buffer_if.master           mem
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [AW-1:0] entry_addr [DEPTH];
    logic [DW-1:0] entry_data [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_data_q;

    logic          read_valid_q;
    logic [DW-1:0] read_data_q;

    logic          push;
    logic          pop;
    logic          load_req;

    logic          hit;
    logic [DW-1:0] hit_data;
    logic [PW-1:0] idx;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    assign overflow   = overflow_q;
    assign read_valid = read_valid_q;
    assign read_data  = read_data_q;

    assign mem.mem_req  = (state_q == REQ);
    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_data = mem_data_q;

    // A full buffer refuses pushes even when a pop lands on the same edge.
    assign push = wr_en && !full;

    // Drain FSM next state: launch a request when idle with work, retire on ack.
    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d  = REQ;
                    load_req = 1'b1;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    state_d = IDLE;
                    pop     = 1'b1;
                end
            end
        endcase
    end

    // Drain FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Walk entries oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (entry_valid[idx] && (entry_addr[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = entry_data[idx];
            end
        end
    end

    // Entry payload storage; contents are meaningless until valid is set.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr[tail_q] <= wr_addr;
            entry_data[tail_q] <= wr_data;
        end
    end

    // Pointers, occupancy, valid bits and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            entry_valid <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (push) begin
                entry_valid[tail_q] <= 1'b1;
                tail_q              <= tail_q + PW'(1);
            end
            if (pop) begin
                entry_valid[head_q] <= 1'b0;
                head_q              <= head_q + PW'(1);
            end
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Capture the head entry when a drain request is launched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else if (load_req) begin
            mem_addr_q <= entry_addr[head_q];
            mem_data_q <= entry_data[head_q];
        end
    end

    // Register the forwarding result; a miss returns zero data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_valid_q <= 1'b0;
            read_data_q  <= '0;
        end else begin
            read_valid_q <= lookup_en && hit;
            read_data_q  <= (lookup_en && hit) ? hit_data : '0;
        end
    end

endmodule
